fpu_share_arbiter: RTL and testbench

- Shares one ieee754_sp floating-point unit (go/done handshake, op, a, b, d) among NREQ requesters, e.g. several w452-class cores or a core plus a DMA/vector helper.
- Arbitrates round-robin and latches the winner's operands.
- Drives the FPU for one operation at a time and returns the result to the winning requester.
- Includes a watchdog so a hung FPU cannot deadlock the requesters.

---
 rtl/fpu_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_fpu_share_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arbiter.sv
// rtl/fpu_share_arbiter.sv - round-robin sharing of one ieee754_sp FPU among NREQ requesters
//
// One operation at a time: IDLE grants and latches operands, ISSUE pulses go,
// WAIT waits for done under a watchdog, RESP returns the result to the winner.
//
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   req_valid[NREQ]         requester i has an operation pending
//   req_op/req_a/req_b      packed per-requester op (2b) and operands (32b)
//   req_ready[NREQ]         one-hot accept strobe (combinational, IDLE only)
//   rsp_valid[NREQ]         one-hot one-cycle result strobe
//   rsp_data, rsp_err       result word; err marks a watchdog abort (quiet NaN)
//   fpu_op/fpu_a/fpu_b/go   command side of the shared FPU
//   fpu_done, fpu_d         completion pulse and result from the FPU
//   busy                    high whenever an operation is in flight
module fpu_share_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic [1:0]           fpu_op,
  output logic [31:0]          fpu_a,
  output logic [31:0]          fpu_b,
  output logic                 fpu_go,
  input  logic                 fpu_done,
  input  logic [31:0]          fpu_d,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt;
  logic [7:0]      wdog;
  logic [IW:0]     pick;
  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic            wdog_expired;

  // Search upward from ptr+1 with wrap. Iterating from the farthest candidate
  // down lets the nearest pending requester overwrite the result last.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] v,
                                          input logic [IW-1:0]   p);
    logic [IW:0] r;
    int          c;
    r = '0;
    for (int k = NREQ; k >= 1; k--) begin
      c = (int'(p) + k) % NREQ;
      if (v[c]) r = {1'b1, c[IW-1:0]};
    end
    return r;
  endfunction

  always_comb pick = rr_pick(req_valid, ptr);
  assign pick_any     = pick[IW];
  assign pick_idx     = pick[IW-1:0];
  assign wdog_expired = (wdog == 8'(TIMEOUT - 1));
  assign fpu_go       = (state == ISSUE);
  assign busy         = (state != IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready[pick_idx] = 1'b1;
          state_nxt           = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (fpu_done || wdog_expired) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[gnt] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The accept strobe is combinational from req_valid; keep it quiet while
    // reset is held so nothing looks accepted by a block that is being cleared.
    if (reset) req_ready = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= IW'(NREQ - 1);
      gnt      <= '0;
      wdog     <= '0;
      fpu_op   <= '0;
      fpu_a    <= '0;
      fpu_b    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt    <= pick_idx;
            fpu_op <= req_op[2*int'(pick_idx) +: 2];
            fpu_a  <= req_a[32*int'(pick_idx) +: 32];
            fpu_b  <= req_b[32*int'(pick_idx) +: 32];
          end
        end
        ISSUE: wdog <= '0;
        WAIT: begin
          wdog <= wdog + 8'd1;
          // done has priority over an expiring watchdog in the same cycle
          if (fpu_done) begin
            rsp_data <= fpu_d;
            rsp_err  <= 1'b0;
          end else if (wdog_expired) begin
            rsp_data <= QNAN;
            rsp_err  <= 1'b1;
          end
        end
        RESP: begin
          ptr     <= gnt;
          rsp_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb/tb_fpu_share_arbiter.sv - self-checking bench for fpu_share_arbiter
module tb_fpu_share_arbiter;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] F1 = 32'h3F80_0000, F2 = 32'h4000_0000, F3 = 32'h4040_0000;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [2*NREQ-1:0]  req_op = '0;
  logic [32*NREQ-1:0] req_a = '0;
  logic [32*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]    req_ready, rsp_valid;
  logic [31:0]        rsp_data;
  logic               rsp_err;
  logic [1:0]         fpu_op;
  logic [31:0]        fpu_a, fpu_b;
  logic               fpu_go;
  logic               fpu_done = 1'b0;
  logic [31:0]        fpu_d = '0;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fpu_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .fpu_op(fpu_op), .fpu_a(fpu_a),
    .fpu_b(fpu_b), .fpu_go(fpu_go), .fpu_done(fpu_done), .fpu_d(fpu_d), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FPU stand-in ----------------
  int          fpu_lat = 4;
  bit          fpu_hang = 1'b0;
  int          inj_cyc = -1;
  int          done_cyc = -1;
  bit          done_pend = 1'b0;
  logic [31:0] done_val = '0;

  function automatic logic [31:0] fres(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    if (op == 2'd0 && a == F1 && b == F2) return F2;
    if (op == 2'd2 && a == F1 && b == F2) return F3;
    if (op == 2'd3 && a == F3 && b == F1) return F2;
    return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
  endfunction

  always @(posedge clk) begin
    #1;
    if (done_pend && cyc == done_cyc) begin
      fpu_done = 1'b1;
      fpu_d    = done_val;
    end else if (cyc == inj_cyc) begin
      fpu_done = 1'b1;
      fpu_d    = 32'hBAD0_0000 | 32'(cyc);
    end else begin
      fpu_done = 1'b0;
      fpu_d    = 32'hDEAD_BEEF;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  function automatic int rr_next(logic [NREQ-1:0] v, int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  bit          m_out = 1'b0;
  int          m_g = 0, m_last = NREQ - 1, m_acc = 0, m_rsp = 0;
  logic [1:0]  m_op;
  logic [31:0] m_a, m_b, m_data;
  bit          m_err;

  always @(negedge clk) begin
    logic [NREQ-1:0] e_ready, e_rsp;
    bit              outb;
    int              lat;
    if (reset) begin
      m_out     = 1'b0;
      m_last    = NREQ - 1;
      done_pend = 1'b0;
    end else begin
      outb    = m_out;
      e_ready = '0;
      if (!outb && req_valid != '0) e_ready[rr_next(req_valid, m_last)] = 1'b1;
      checks++;
      if (req_ready !== e_ready) begin
        errors++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready);
      end
      checks++;
      if (busy !== outb) begin
        errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, outb);
      end
      checks++;
      if (fpu_go !== (outb && cyc == m_acc + 1)) begin
        errors++; $display("FAIL fpu_go cyc=%0d got=%b exp=%b", cyc, fpu_go, outb && cyc == m_acc + 1);
      end
      if (outb && cyc > m_acc && cyc < m_rsp) begin
        checks++;
        if ({fpu_op, fpu_a, fpu_b} !== {m_op, m_a, m_b}) begin
          errors++; $display("FAIL fpu_operands cyc=%0d got=%h/%h/%h exp=%h/%h/%h",
                             cyc, fpu_op, fpu_a, fpu_b, m_op, m_a, m_b);
        end
      end
      e_rsp = '0;
      if (outb && cyc == m_rsp) e_rsp[m_g] = 1'b1;
      checks++;
      if (rsp_valid !== e_rsp) begin
        errors++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rsp);
      end
      checks++;
      if (rsp_err !== ((e_rsp != '0) ? m_err : 1'b0)) begin
        errors++; $display("FAIL rsp_err cyc=%0d got=%b exp=%b", cyc, rsp_err, (e_rsp != '0) ? m_err : 1'b0);
      end
      if (e_rsp != '0) begin
        checks++;
        if (rsp_data !== m_data) begin
          errors++; $display("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, m_data);
        end
        m_last = m_g;
        m_out  = 1'b0;
      end
      if (!outb && req_valid != '0) begin
        m_g   = rr_next(req_valid, m_last);
        m_acc = cyc;
        m_op  = req_op[2*m_g +: 2];
        m_a   = req_a[32*m_g +: 32];
        m_b   = req_b[32*m_g +: 32];
        lat   = fpu_hang ? TIMEOUT + 1 : fpu_lat;
        done_val = fres(m_op, m_a, m_b);
        if (lat <= TIMEOUT) begin
          done_pend = 1'b1;
          done_cyc  = cyc + 1 + lat;
          m_data    = done_val;
          m_err     = 1'b0;
          m_rsp     = cyc + 2 + lat;
        end else begin
          done_pend = 1'b0;
          m_data    = QNAN;
          m_err     = 1'b1;
          m_rsp     = cyc + 2 + TIMEOUT;
        end
        m_out = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(int i, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    req_op[2*i +: 2]   = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_valid[i]       = 1'b1;
  endtask

  task automatic settle_idle();
    for (int k = 0; k < 40 && busy; k++) tick();
  endtask

  // Issue one request from r with the FPU configured beforehand; checks latency and result.
  task automatic one_op(string name, int r, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                        int exp_lat, logic [31:0] exp_d, logic exp_e, int inj_issue);
    int acc;
    bit got;
    settle_idle();
    set_req(r, op, a, b);
    acc = -1;
    for (int k = 0; k < 20 && acc < 0; k++) begin
      @(negedge clk);
      if (req_ready[r]) acc = cyc;
    end
    if (inj_issue != 0) inj_cyc = acc + 1;
    tick();
    req_valid[r] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 30 && !got && acc >= 0; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        got = 1'b1;
        checks++;
        if (rsp_valid !== NREQ'(1 << r) || rsp_data !== exp_d || rsp_err !== exp_e || cyc - acc != exp_lat) begin
          errors++;
          $display("FAIL %s got=%b/%h/%b lat=%0d exp=%b/%h/%b lat=%0d", name, rsp_valid, rsp_data,
                   rsp_err, cyc - acc, NREQ'(1 << r), exp_d, exp_e, exp_lat);
        end
      end
    end
    if (!got) begin
      checks++; errors++; $display("FAIL %s_timeout got=no_response exp=response", name);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b/%b/%b/%b exp=0", req_ready, rsp_valid, rsp_err, busy);
    end
    checks++;
    if (rsp_data !== '0 || fpu_go !== 1'b0 || fpu_op !== '0 || fpu_a !== '0 || fpu_b !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%b/%h/%h/%h exp=0", rsp_data, fpu_go, fpu_op, fpu_a, fpu_b);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    fpu_hang = 1'b0; fpu_lat = 4;
    one_op("single", 0, 2'd0, F1, F2, 6, F2, 1'b0, 0);
  endtask

  task automatic test_simultaneous();
    int order[$];
    logic [31:0] data[$];
    int exp_o[4] = '{0, 1, 0, 1};
    logic [31:0] exp_d[4] = '{F3, F2, F3, F2};
    tick();
    reset = 1'b1;
    fpu_hang = 1'b0; fpu_lat = 2;
    set_req(0, 2'd2, F1, F2);
    set_req(1, 2'd3, F3, F1);
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 60 && order.size() < 4; k++) begin
      @(negedge clk);
      if (rsp_valid == 2'b01) begin order.push_back(0); data.push_back(rsp_data); end
      if (rsp_valid == 2'b10) begin order.push_back(1); data.push_back(rsp_data); end
    end
    req_valid = '0;
    checks++;
    if (order.size() != 4) begin
      errors++; $display("FAIL simult_count got=%0d exp=4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != exp_o[i] || data[i] !== exp_d[i]) begin
          errors++; $display("FAIL simult_%0d got=r%0d/%h exp=r%0d/%h", i, order[i], data[i], exp_o[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] a, b;
    a = $urandom(); b = $urandom();
    fpu_hang = 1'b1;
    one_op("timeout", 1, 2'd1, a, b, TIMEOUT + 2, QNAN, 1'b1, 0);
    @(negedge clk);
    checks++;
    if (rsp_err !== 1'b0 || rsp_data !== QNAN) begin
      errors++; $display("FAIL timeout_after got=%b/%h exp=0/%h", rsp_err, rsp_data, QNAN);
    end
    fpu_hang = 1'b0; fpu_lat = 3;
    one_op("after_timeout", 1, 2'd2, a, b, 5, fres(2'd2, a, b), 1'b0, 0);
  endtask

  task automatic test_stray_done();
    logic [31:0] a, b;
    settle_idle();
    inj_cyc = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
        errors++; $display("FAIL stray_idle got=%b/%b exp=0/0", rsp_valid, busy);
      end
      tick();
    end
    a = $urandom(); b = $urandom();
    fpu_hang = 1'b0; fpu_lat = 3;
    one_op("stray_issue", 0, 2'd0, a, b, 5, fres(2'd0, a, b), 1'b0, 1);
    fpu_lat = TIMEOUT;
    one_op("coincident", 0, 2'd3, b, a, TIMEOUT + 2, fres(2'd3, b, a), 1'b0, 0);
  endtask

  task automatic test_reset_mid_wait();
    int order[$];
    int acc;
    logic [NREQ-1:0] rdy;
    settle_idle();
    fpu_hang = 1'b1;
    set_req(1, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    acc = -1;
    for (int k = 0; k < 20 && acc < 0; k++) begin
      @(negedge clk);
      if (req_ready[1]) acc = cyc;
    end
    tick();
    set_req(0, 2'd2, 32'h0F0F_0F0F, 32'h3333_3333);
    tick(); tick();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_err !== 1'b0 || busy !== 1'b0 || fpu_go !== 1'b0) begin
      errors++; $display("FAIL midreset_ctrl got=%b/%b/%b/%b/%b exp=0", req_ready, rsp_valid, rsp_err, busy, fpu_go);
    end
    checks++;
    if (rsp_data !== '0 || fpu_op !== '0 || fpu_a !== '0 || fpu_b !== '0) begin
      errors++; $display("FAIL midreset_data got=%h/%h/%h/%h exp=0", rsp_data, fpu_op, fpu_a, fpu_b);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0) begin
        errors++; $display("FAIL midreset_rsp got=%b exp=0", rsp_valid);
      end
    end
    tick();
    reset = 1'b0;
    fpu_hang = 1'b0; fpu_lat = 2;
    for (int k = 0; k < 40 && order.size() < 2; k++) begin
      @(negedge clk);
      rdy = req_ready;
      if (rsp_valid == 2'b01) order.push_back(0);
      if (rsp_valid == 2'b10) order.push_back(1);
      tick();
      req_valid = req_valid & ~rdy;
    end
    checks++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
      errors++; $display("FAIL midreset_order got=%0d served first=%0d exp=2 served first=0",
                         order.size(), (order.size() > 0) ? order[0] : -1);
    end
  endtask

  task automatic test_withdraw();
    int acc;
    settle_idle();
    fpu_hang = 1'b0; fpu_lat = 6;
    set_req(0, 2'd0, 32'h1111_1111, 32'h2222_2222);
    acc = -1;
    for (int k = 0; k < 20 && acc < 0; k++) begin
      @(negedge clk);
      if (req_ready[0]) acc = cyc;
    end
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 2'd1, 32'h5555_5555, 32'h6666_6666);
    tick();
    req_valid[1] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
        errors++; $display("FAIL withdraw got=%b/%b exp=0/0", req_ready[1], rsp_valid[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] rdy;
    int n_acc, n_rsp;
    n_acc = 0; n_rsp = 0;
    settle_idle();
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      rdy = req_ready;
      if (req_ready != '0) n_acc++;
      if (rsp_valid != '0) n_rsp++;
      tick();
      fpu_lat  = $urandom_range(1, TIMEOUT);
      fpu_hang = ($urandom_range(0, 11) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && rdy[i]) begin
          if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
          else set_req(i, 2'($urandom_range(0, 3)), $urandom(), $urandom());
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 2'($urandom_range(0, 3)), $urandom(), $urandom());
        end
      end
    end
    req_valid = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready != '0) n_acc++;
      if (rsp_valid != '0) n_rsp++;
    end
    checks++;
    if (n_acc != n_rsp || busy !== 1'b0) begin
      errors++; $display("FAIL random_drain got=acc%0d/rsp%0d/busy%b exp=equal/0", n_acc, n_rsp, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_timeout();
    test_stray_done();
    test_reset_mid_wait();
    test_withdraw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
